// File: rtl/perceptron_bp.sv
// Global-history perceptron branch predictor with on-line training and history repair.
// Latency: prediction registered one cycle after pred_req_i; training read-modify-write completes in the res_valid_i cycle.
// Backpressure: none; a request and a resolution are accepted every cycle.
//
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   pred_req_i/idx_i  - fetch-side prediction request and table index
//   pred_*_o          - registered prediction: valid pulse, direction, sum, BHR snapshot
//   res_*_i           - execute-side resolution: index, BHR/sum snapshot, outcome, mispredict
//   bhr_o             - current speculative global history
module perceptron_bp #(
  parameter int PT_IDX_W = 6,
  parameter int BHR_W    = 8,
  parameter int WEIGHT_W = 8,
  parameter int THETA    = 29,
  parameter int SUM_W    = WEIGHT_W + $clog2(BHR_W + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    pred_req_i,
  input  logic [PT_IDX_W-1:0]     pred_idx_i,
  output logic                    pred_valid_o,
  output logic                    pred_taken_o,
  output logic signed [SUM_W-1:0] pred_sum_o,
  output logic [BHR_W-1:0]        pred_bhr_o,
  input  logic                    res_valid_i,
  input  logic [PT_IDX_W-1:0]     res_idx_i,
  input  logic [BHR_W-1:0]        res_bhr_i,
  input  logic signed [SUM_W-1:0] res_sum_i,
  input  logic                    res_taken_i,
  input  logic                    res_mispred_i,
  output logic [BHR_W-1:0]        bhr_o
);

  localparam int NUM_ENT = 1 << PT_IDX_W;
  localparam int NUM_W   = BHR_W + 1;

  localparam logic signed [WEIGHT_W-1:0] W_MAX = {1'b0, {(WEIGHT_W-1){1'b1}}};
  localparam logic signed [WEIGHT_W-1:0] W_MIN = {1'b1, {(WEIGHT_W-1){1'b0}}};
  localparam logic signed [WEIGHT_W-1:0] W_ONE = 1;
  localparam logic [SUM_W-1:0]           THETA_V = SUM_W'(THETA);

  // Weight table: entry e, weight 0 is the bias, weight i pairs with history bit i-1.
  logic signed [WEIGHT_W-1:0] wt [NUM_ENT][NUM_W];
  logic [BHR_W-1:0]           bhr;

  logic signed [SUM_W-1:0]    sum_c;
  logic                       taken_c;

  logic                       res_pred_dir;
  logic [SUM_W-1:0]           res_mag;
  logic                       do_train;
  logic                       do_repair;
  logic signed [WEIGHT_W-1:0] upd_w [NUM_W];

  function automatic logic signed [SUM_W-1:0] sext(input logic signed [WEIGHT_W-1:0] w);
    return {{(SUM_W-WEIGHT_W){w[WEIGHT_W-1]}}, w};
  endfunction

  // One saturating step of +1 (up) or -1 (down); pins at the signed rails.
  function automatic logic signed [WEIGHT_W-1:0] sat_step(input logic signed [WEIGHT_W-1:0] w,
                                                          input logic up);
    logic signed [WEIGHT_W-1:0] r;
    r = w;
    if (up) begin
      if (w != W_MAX) r = w + W_ONE;
    end else begin
      if (w != W_MIN) r = w - W_ONE;
    end
    return r;
  endfunction

  // Dot product against the current speculative history. Adding or subtracting
  // each weight implements x_i = +1/-1 without a multiplier. SUM_W is wide
  // enough that h+1 extreme weights never overflow.
  always_comb begin
    sum_c = sext(wt[pred_idx_i][0]);
    for (int i = 1; i < NUM_W; i++) begin
      if (bhr[i-1]) sum_c = sum_c + sext(wt[pred_idx_i][i]);
      else          sum_c = sum_c - sext(wt[pred_idx_i][i]);
    end
    taken_c = ~sum_c[SUM_W-1];
  end

  // Training decision uses the sum captured at prediction time, not a re-read,
  // so it reflects exactly what fetch acted on.
  always_comb begin
    res_pred_dir = ~res_sum_i[SUM_W-1];
    res_mag      = res_sum_i[SUM_W-1] ? -res_sum_i : res_sum_i;
    do_train     = res_valid_i && ((res_pred_dir != res_taken_i) || (res_mag <= THETA_V));
    do_repair    = res_valid_i && res_mispred_i;
  end

  // New weights for the resolved entry. t*x_i is +1 when outcome and history
  // bit agree, -1 otherwise; the bias always moves toward the outcome.
  always_comb begin
    upd_w[0] = sat_step(wt[res_idx_i][0], res_taken_i);
    for (int i = 1; i < NUM_W; i++) begin
      upd_w[i] = sat_step(wt[res_idx_i][i], res_taken_i == res_bhr_i[i-1]);
    end
  end

  // Table update. The prediction path reads wt combinationally in the same
  // cycle, so a colliding prediction naturally sees the pre-update weights.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int e = 0; e < NUM_ENT; e++) begin
        for (int i = 0; i < NUM_W; i++) begin
          wt[e][i] <= '0;
        end
      end
    end else if (do_train) begin
      for (int i = 0; i < NUM_W; i++) begin
        wt[res_idx_i][i] <= upd_w[i];
      end
    end
  end

  // Speculative history. Repair takes priority: a prediction issued in the same
  // cycle used the wrong path's history and will be squashed by execute.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bhr <= '0;
    end else if (do_repair) begin
      bhr <= {res_bhr_i[BHR_W-2:0], res_taken_i};
    end else if (pred_req_i) begin
      bhr <= {bhr[BHR_W-2:0], taken_c};
    end
  end

  // Prediction outputs hold between requests; only the valid flag pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_valid_o <= 1'b0;
      pred_taken_o <= 1'b0;
      pred_sum_o   <= '0;
      pred_bhr_o   <= '0;
    end else begin
      pred_valid_o <= pred_req_i;
      if (pred_req_i) begin
        pred_taken_o <= taken_c;
        pred_sum_o   <= sum_c;
        pred_bhr_o   <= bhr;
      end
    end
  end

  assign bhr_o = bhr;

endmodule
